// File: rtl/dphy_rx_word_aligner.sv
// D-PHY HS receive word aligner: hunts the sync byte across two deserialized words,
// locks the bit offset and emits byte-aligned payload with SoT/EoT/error strobes.
module dphy_rx_word_aligner #(
   parameter logic [7:0]  g_sync_byte    = 8'hB8,
   parameter int unsigned g_hunt_timeout = 16
) (
   input  logic       clk_word_i,
   input  logic       rst_n_a_i,
   input  logic       en_i,
   input  logic [7:0] raw_i,
   output logic [7:0] q_o,
   output logic       valid_o,
   output logic       sot_o,
   output logic       sot_err_o,
   output logic       eot_o,
   output logic       locked_o,
   output logic [2:0] shift_o
);

   typedef enum logic [1:0] {S_IDLE, S_HUNT, S_LOCKED, S_FAIL} state_t;

   localparam logic [7:0] HUNT_LAST = 8'(g_hunt_timeout - 1);

   state_t      state, state_nxt;
   logic [7:0]  cnt, cnt_nxt;
   logic [7:0]  word_p0, word_p1;
   logic [15:0] win;
   logic        hit;
   logic [2:0]  hit_s;
   logic [7:0]  q_nxt;
   logic        valid_nxt, sot_nxt, sot_err_nxt, eot_nxt;
   logic [2:0]  shift_nxt;

   // {hit, offset}; scanning downward lets the lowest matching offset win
   function automatic logic [3:0] find_sync(input logic [15:0] w);
      logic [3:0] res;
      res = 4'b0;
      for (int s = 7; s >= 0; s--) begin
         if (w[s +: 8] == g_sync_byte) res = {1'b1, 3'(s)};
      end
      return res;
   endfunction

   // stage p0/p1: two-word input pipe, flushed while the lane is not in HS mode
   always_ff @(posedge clk_word_i or negedge rst_n_a_i) begin
      if (!rst_n_a_i) begin
         word_p0 <= '0;
         word_p1 <= '0;
      end else if (!en_i) begin
         word_p0 <= '0;
         word_p1 <= '0;
      end else begin
         word_p1 <= word_p0;
         word_p0 <= raw_i;
      end
   end

   assign win          = {word_p0, word_p1};
   assign {hit, hit_s} = find_sync(win);
   assign locked_o     = (state == S_LOCKED);

   always_ff @(posedge clk_word_i or negedge rst_n_a_i) begin
      if (!rst_n_a_i) begin
         state     <= S_IDLE;
         cnt       <= '0;
         q_o       <= '0;
         valid_o   <= 1'b0;
         sot_o     <= 1'b0;
         sot_err_o <= 1'b0;
         eot_o     <= 1'b0;
         shift_o   <= '0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         q_o       <= q_nxt;
         valid_o   <= valid_nxt;
         sot_o     <= sot_nxt;
         sot_err_o <= sot_err_nxt;
         eot_o     <= eot_nxt;
         shift_o   <= shift_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      if (!en_i) begin
         state_nxt = S_IDLE;
      end else begin
         case (state)
            S_IDLE: begin
               state_nxt = S_HUNT;
               cnt_nxt   = '0;
            end
            S_HUNT: begin
               if (hit)                    state_nxt = S_LOCKED;
               else if (cnt == HUNT_LAST)  state_nxt = S_FAIL;
               else                        cnt_nxt   = cnt + 8'd1;
            end
            default: state_nxt = state;
         endcase
      end
   end

   // stage p2: registered payload and strobes
   always_comb begin
      q_nxt       = q_o;
      valid_nxt   = 1'b0;
      sot_nxt     = 1'b0;
      sot_err_nxt = 1'b0;
      eot_nxt     = 1'b0;
      shift_nxt   = shift_o;
      if (!en_i) begin
         eot_nxt = (state == S_LOCKED);
      end else begin
         case (state)
            S_HUNT: begin
               if (hit) begin
                  sot_nxt   = 1'b1;
                  shift_nxt = hit_s;
               end else if (cnt == HUNT_LAST) begin
                  sot_err_nxt = 1'b1;
               end
            end
            S_LOCKED: begin
               q_nxt     = win[shift_o +: 8];
               valid_nxt = 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_dphy_rx_word_aligner.sv
// Bench for dphy_rx_word_aligner: directed lock/timeout/EoT/reset cases plus random
// traffic compared every cycle against a bit-window reference model.
module tb_dphy_rx_word_aligner;

   localparam logic [7:0] SYNC    = 8'hB8;
   localparam int         TIMEOUT = 16;
   localparam int M_IDLE = 0, M_HUNT = 1, M_LOCKED = 2, M_FAIL = 3;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       en;
   logic [7:0] raw;
   logic [7:0] q;
   logic       valid, sot, sot_err, eot, locked;
   logic [2:0] shift;

   int n_vec  = 0;
   int n_bad  = 0;
   bit chk_on = 1'b0;

   dphy_rx_word_aligner #(.g_sync_byte(SYNC), .g_hunt_timeout(TIMEOUT)) dut (
      .clk_word_i(clk), .rst_n_a_i(rst_n), .en_i(en), .raw_i(raw),
      .q_o(q), .valid_o(valid), .sot_o(sot), .sot_err_o(sot_err),
      .eot_o(eot), .locked_o(locked), .shift_o(shift)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: last two received words, mode, and words spent hunting
   logic [7:0] m_new = 0, m_old = 0, m_q = 0;
   int m_mode = M_IDLE, m_hunt = 0, m_shift = 0;
   bit m_valid = 0, m_sot = 0, m_err = 0, m_eot = 0;

   task automatic model_reset();
      m_new = 0; m_old = 0; m_q = 0; m_mode = M_IDLE; m_hunt = 0; m_shift = 0;
      m_valid = 0; m_sot = 0; m_err = 0; m_eot = 0;
   endtask

   task automatic model_step();
      logic [15:0] w;
      int found;
      w = {m_new, m_old};
      m_sot = 0; m_err = 0; m_eot = 0; m_valid = 0;
      if (!en) begin
         m_eot  = (m_mode == M_LOCKED);
         m_mode = M_IDLE;
      end else if (m_mode == M_IDLE) begin
         m_mode = M_HUNT;
         m_hunt = 0;
      end else if (m_mode == M_HUNT) begin
         found = -1;
         for (int s = 0; s < 8 && found < 0; s++)
            if (8'(w >> s) == SYNC) found = s;
         m_hunt++;
         if (found >= 0) begin
            m_mode = M_LOCKED; m_shift = found; m_sot = 1;
         end else if (m_hunt == TIMEOUT) begin
            m_mode = M_FAIL; m_err = 1;
         end
      end else if (m_mode == M_LOCKED) begin
         m_q = 8'(w >> m_shift);
         m_valid = 1;
      end
      if (!en) begin
         m_new = 0; m_old = 0;
      end else begin
         m_old = m_new; m_new = raw;
      end
   endtask

   always @(posedge clk) begin
      if (rst_n) model_step();
      else model_reset();
   end
   always @(negedge rst_n) model_reset();

   always @(negedge clk) begin
      if (chk_on) begin
         chk("q", q, m_q);
         chk("valid", valid, m_valid);
         chk("sot", sot, m_sot);
         chk("sot_err", sot_err, m_err);
         chk("eot", eot, m_eot);
         chk("locked", locked, int'(m_mode == M_LOCKED));
         chk("shift", shift, m_shift);
      end
   end

   task automatic step(input logic e, input logic [7:0] r);
      @(negedge clk);
      en  = e;
      raw = r;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_q"}, q, 0);
      chk({tag, "_valid"}, valid, 0);
      chk({tag, "_sot"}, sot, 0);
      chk({tag, "_err"}, sot_err, 0);
      chk({tag, "_eot"}, eot, 0);
      chk({tag, "_locked"}, locked, 0);
      chk({tag, "_shift"}, shift, 0);
   endtask

   task automatic async_reset();
      #2 rst_n = 1'b0;
      #1 chk_all_zero("arst");
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic t1();
      step(1, 8'h00); step(1, 8'h00); step(1, 8'hB8); step(1, 8'h12);
      chk("t1_nosot_early", sot, 0);
      step(1, 8'h34);
      chk("t1_sot", sot, 1); chk("t1_shift", shift, 0); chk("t1_valid_at_sot", valid, 0);
      step(1, 8'h56);
      chk("t1_q0", q, 8'h12); chk("t1_v0", valid, 1); chk("t1_sot_off", sot, 0);
      step(1, 8'h78);
      chk("t1_q1", q, 8'h34); chk("t1_v1", valid, 1);
      step(0, 8'h00);
      chk("t1_eot", eot, 1); chk("t1_valid_end", valid, 0);
      chk("t1_locked_end", locked, 0); chk("t1_q_hold", q, 8'h34);
      step(0, 8'h00);
      chk("t1_eot_off", eot, 0);
   endtask

   initial begin
      logic       e;
      logic [7:0] r;
      logic [15:0] inj;
      int s, low_left;
      bit pend;
      low_left = 0; pend = 0; inj = '0;

      rst_n = 1'b0; en = 1'b0; raw = 8'h00;
      repeat (2) @(posedge clk);
      #1 chk_all_zero("reset");
      chk_on = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;

      // T1: shift 0
      t1();

      // T2: shift 3, then drop en mid-payload (T5)
      step(1, 8'h00); step(1, 8'hC0); step(1, 8'h2D); step(1, 8'h05);
      chk("t2_sot", sot, 1); chk("t2_shift", shift, 3);
      step(1, 8'hFF);
      chk("t2_q0", q, 8'hA5); chk("t2_v0", valid, 1);
      step(1, 8'h11);
      chk("t5_q1", q, 8'hE0);
      step(0, 8'h00);
      chk("t5_valid_off", valid, 0); chk("t5_eot", eot, 1);
      step(0, 8'h00);
      // relock at a different offset
      t1();

      // T3: hunt timeout, sync afterwards is ignored
      for (int k = 1; k <= 17; k++) begin
         step(1, 8'h00);
         if (k == 16) chk("t3_err_early", sot_err, 0);
      end
      chk("t3_err", sot_err, 1); chk("t3_locked", locked, 0);
      step(1, 8'hB8); chk("t3_err_once", sot_err, 0);
      step(1, 8'h12); step(1, 8'h34);
      chk("t3_no_lock", locked, 0); chk("t3_no_sot", sot, 0); chk("t3_no_valid", valid, 0);
      step(0, 8'h00); chk("t3_no_eot", eot, 0);

      // one-cycle en pulse: no strobes
      step(1, 8'hB8); step(0, 8'h00);
      chk("pulse_sot", sot, 0); chk("pulse_eot", eot, 0);

      // T6: reset while LOCKED, then a fresh T1
      step(1, 8'h00); step(1, 8'h00); step(1, 8'hB8); step(1, 8'h12);
      step(1, 8'h34); step(1, 8'h56);
      chk("t6_pre_valid", valid, 1);
      async_reset();
      step(0, 8'h00);
      chk("t6_no_eot", eot, 0);
      t1();

      // random traffic with injected sync bytes at random offsets
      for (int i = 0; i < 3000; i++) begin
         if (low_left > 0) begin
            low_left--; e = 1'b0;
         end else if ($urandom_range(0, 39) == 0) begin
            low_left = $urandom_range(0, 3); e = 1'b0;
         end else begin
            e = 1'b1;
         end
         if (pend) begin
            r = inj[15:8]; pend = 0;
         end else if ($urandom_range(0, 19) == 0) begin
            s   = $urandom_range(0, 7);
            inj = 16'($urandom);
            inj = (inj & ~(16'h00FF << s)) | (16'(SYNC) << s);
            r   = inj[7:0]; pend = 1;
         end else begin
            r = 8'($urandom);
         end
         step(e, r);
         if (i % 1000 == 500) async_reset();
      end

      step(0, 8'h00);
      @(negedge clk);
      #1;
      chk_on = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
